fetch_unit: RTL and testbench

Unpipelined instruction fetch sequencer for the RISCV32I core: it holds the fetch PC, issues one instruction-memory read at a time, and hands the fetched instruction with its PC and PC+4 to decode over a valid/ready handshake. It consumes branch/jump targets from execute as redirects and computes the sequential next PC itself. At most one memory request is outstanding, so peak throughput is one instruction per three cycles.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : single-outstanding RV32I instruction fetch sequencer
// Rev 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nxt;
  logic        flush_q;
  logic        flush_nxt;
  logic [31:0] target_q;
  logic [31:0] target_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic [31:0] instr_q;
  logic [31:0] instr_nxt;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      flush_q  <= 1'b0;
      target_q <= 32'h0000_0000;
      pc_q     <= 32'h0000_0000;
      instr_q  <= NOP_INSTR;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      flush_q  <= flush_nxt;
      target_q <= target_nxt;
      pc_q     <= pc_nxt;
      instr_q  <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    flush_nxt    = flush_q;
    target_nxt   = target_q;
    pc_nxt       = pc_q;
    instr_nxt    = instr_q;

    unique case (state)
      BOOT: begin
        fetch_pc_nxt = RESET_PC;
        state_nxt    = REQ;
      end

      REQ: begin
        // The issued request cannot be withdrawn; remember where to go once its
        // response has been drained.
        if (redirect_valid) begin
          flush_nxt  = 1'b1;
          target_nxt = redirect_aligned;
        end
        if (imem_req_ready) begin
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (imem_rsp_valid) begin
          if (flush_q || redirect_valid) begin
            fetch_pc_nxt = redirect_valid ? redirect_aligned : target_q;
            flush_nxt    = 1'b0;
            state_nxt    = REQ;
          end else begin
            pc_nxt    = fetch_pc;
            instr_nxt = imem_rsp_data;
            state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          flush_nxt  = 1'b1;
          target_nxt = redirect_aligned;
        end
      end

      HOLD: begin
        // A redirect drops the held instruction even if decode takes it.
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_aligned;
          state_nxt    = REQ;
        end else if (if_ready) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = REQ;
        end
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = fetch_pc;
  assign if_valid       = (state == HOLD);
  assign if_pc          = pc_q;
  assign if_instr       = instr_q;
  assign if_pc_plus4    = pc_q + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed and randomized checks of fetch_unit
// Rev 1.0
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;

  int passed = 0;
  int total  = 0;

  // memory model: one pending read, response latency 1..lat_max cycles
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_max;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_pc_plus4    (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Advance one clock; inputs and outputs are handled #1 after the edge.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (acc) begin
      mem_pend = 1'b1;
      mem_addr = a;
      mem_cnt  = $urandom_range(0, lat_max - 1);
    end
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pend       = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== RST_PC) $display("FAIL reset_req_addr got=%h exp=%h", imem_req_addr, RST_PC); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid got=%0b exp=0", if_valid); else passed++;
    total++; if (if_pc !== 32'h0) $display("FAIL reset_if_pc got=%h exp=0", if_pc); else passed++;
    total++; if (if_instr !== 32'h13) $display("FAIL reset_if_instr got=%h exp=00000013", if_instr); else passed++;
    total++; if (if_pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4 got=%h exp=4", if_pc_plus4); else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] p;
    rst_n = 1'b1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL boot_req_valid got=%0b exp=0", imem_req_valid); else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      p = RST_PC + 32'(4 * i);
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== p)
        $display("FAIL seq_req[%0d] got v=%0b a=%h exp v=1 a=%h", i, imem_req_valid, imem_req_addr, p); else passed++;
      tick();
      total++; if (if_valid !== 1'b0) $display("FAIL seq_wait_valid[%0d] got=%0b exp=0", i, if_valid); else passed++;
      tick();
      total++; if (if_valid !== 1'b1 || if_pc !== p || if_instr !== mem_word(p) || if_pc_plus4 !== p + 32'd4)
        $display("FAIL seq_out[%0d] got v=%0b pc=%h i=%h p4=%h exp pc=%h i=%h", i, if_valid, if_pc, if_instr, if_pc_plus4, p, mem_word(p)); else passed++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    if_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h10C || if_instr !== mem_word(32'h10C) || imem_req_valid !== 1'b0)
        $display("FAIL stall[%0d] got v=%0b pc=%h i=%h rq=%0b exp v=1 pc=0000010c rq=0", i, if_valid, if_pc, if_instr, imem_req_valid); else passed++;
      tick();
    end
    if_ready = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h110)
      $display("FAIL stall_release got v=%0b a=%h exp v=1 a=00000110", imem_req_valid, imem_req_addr); else passed++;
  endtask

  task automatic test_redirect_hold();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400 || if_valid !== 1'b0)
      $display("FAIL hold_redirect got v=%0b a=%h iv=%0b exp v=1 a=00000400 iv=0", imem_req_valid, imem_req_addr, if_valid); else passed++;
    tick();
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h400 || if_instr !== mem_word(32'h400))
      $display("FAIL hold_redirect_out got v=%0b pc=%h i=%h exp pc=00000400", if_valid, if_pc, if_instr); else passed++;
  endtask

  task automatic test_redirect_wait();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req_addr !== 32'h10) $display("FAIL wait_setup got=%h exp=00000010", imem_req_addr); else passed++;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200 || if_valid !== 1'b0)
      $display("FAIL wait_redirect got v=%0b a=%h iv=%0b exp v=1 a=00000200 iv=0", imem_req_valid, imem_req_addr, if_valid); else passed++;
    tick();
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== mem_word(32'h200))
      $display("FAIL wait_redirect_out got v=%0b pc=%h i=%h exp pc=00000200", if_valid, if_pc, if_instr); else passed++;
  endtask

  task automatic test_redirect_req();
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) imem_req_ready = 1'b1;
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h204)
        $display("FAIL req_stable[%0d] got v=%0b a=%h exp v=1 a=00000204", i, imem_req_valid, imem_req_addr); else passed++;
      tick();
      redirect_valid = 1'b0;
    end
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80 || if_valid !== 1'b0)
      $display("FAIL req_redirect got v=%0b a=%h iv=%0b exp v=1 a=00000080 iv=0", imem_req_valid, imem_req_addr, if_valid); else passed++;
    tick();
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_instr !== mem_word(32'h80))
      $display("FAIL req_redirect_out got v=%0b pc=%h i=%h exp pc=00000080", if_valid, if_pc, if_instr); else passed++;
  endtask

  task automatic test_wrap();
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req got=%h exp=fffffffc", imem_req_addr); else passed++;
    tick();
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0)
      $display("FAIL wrap_out got v=%0b pc=%h p4=%h exp pc=fffffffc p4=00000000", if_valid, if_pc, if_pc_plus4); else passed++;
    if_ready = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
      $display("FAIL wrap_next got v=%0b a=%h exp v=1 a=00000000", imem_req_valid, imem_req_addr); else passed++;
  endtask

  task automatic test_async_reset();
    tick();
    rst_n = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC || if_valid !== 1'b0 ||
                 if_pc !== 32'h0 || if_instr !== 32'h13 || if_pc_plus4 !== 32'h4)
      $display("FAIL async_reset got rv=%0b a=%h iv=%0b pc=%h i=%h p4=%h", imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_pc_plus4); else passed++;
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    mem_pend       = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    total++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)
      $display("FAIL boot_rsp_ignored got iv=%0b rv=%0b a=%h exp iv=0 rv=1 a=%h", if_valid, imem_req_valid, imem_req_addr, RST_PC); else passed++;
    tick();
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== mem_word(RST_PC))
      $display("FAIL after_reset_out got v=%0b pc=%h i=%h exp pc=%h", if_valid, if_pc, if_instr, RST_PC); else passed++;
  endtask

  // Architectural model: the next instruction handed to decode is at the last
  // redirect target, or at the consumed PC + 4.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        prev_stall;
    logic [31:0] prev_addr;
    int          idle;
    int          delivered;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    mem_pend       = 1'b0;
    imem_rsp_valid = 1'b0;
    lat_max        = 3;
    exp_pc         = RST_PC;
    prev_stall     = 1'b0;
    prev_addr      = 32'h0;
    idle           = 0;
    delivered      = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = (cyc > 0) && ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if (prev_stall) begin
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr)
          $display("FAIL rnd_req_hold[%0d] got v=%0b a=%h exp v=1 a=%h", cyc, imem_req_valid, imem_req_addr, prev_addr); else passed++;
      end
      if (if_valid === 1'b1) begin
        idle = 0;
        total++; if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc) || if_pc_plus4 !== exp_pc + 32'd4)
          $display("FAIL rnd_out[%0d] got pc=%h i=%h p4=%h exp pc=%h i=%h", cyc, if_pc, if_instr, if_pc_plus4, exp_pc, mem_word(exp_pc)); else passed++;
      end else begin
        idle++;
      end
      if (idle > 200) begin
        total++;
        $display("FAIL rnd_timeout[%0d] got no if_valid for %0d cycles exp delivery", cyc, idle);
        break;
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
      if (redirect_valid) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (if_valid && if_ready) begin
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      tick();
    end
    redirect_valid = 1'b0;
    total++; if (delivered < 20) $display("FAIL rnd_progress got=%0d exp>=20", delivered); else passed++;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if_ready       = 1'b1;
    mem_pend       = 1'b0;
    mem_addr       = 32'h0;
    mem_cnt        = 0;
    lat_max        = 1;

    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_hold();
    test_redirect_wait();
    test_redirect_req();
    test_wrap();
    test_async_reset();
    test_random();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
